// File: rtl/l1_data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: word port toward the
// load/store queue, whole-line refill/evict port toward the memory arbiter.
module l1_data_cache #(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [3:0]                mem_byte_enable,
  input  logic [31:0]               mem_address,
  input  logic [31:0]               mem_wdata,
  output logic                      mem_resp,
  output logic [31:0]               mem_rdata,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [31:0]               pmem_address,
  output logic [(8<<S_OFFSET)-1:0]  pmem_wdata,
  input  logic [(8<<S_OFFSET)-1:0]  pmem_rdata,
  input  logic                      pmem_resp
);

  localparam int S_TAG   = 32 - S_INDEX - S_OFFSET;
  localparam int S_WORD  = S_OFFSET - 2;
  localparam int S_LINE  = 8 << S_OFFSET;
  localparam int N_LINES = 1 << S_INDEX;

  // Handshake: the requester raises mem_read/mem_write and holds request,
  // address and data until the single-cycle mem_resp; the cache holds
  // pmem_read/pmem_write, pmem_address and pmem_wdata until the single-cycle
  // pmem_resp. Exactly one transaction is outstanding on each side.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    WRITEBACK = 2'd2,
    FILL      = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [S_TAG-1:0]   req_tag;
  logic [S_INDEX-1:0] req_index;
  logic [S_WORD-1:0]  req_word;
  logic               addr_unused;

  assign req_tag     = mem_address[31 -: S_TAG];
  assign req_index   = mem_address[S_OFFSET +: S_INDEX];
  assign req_word    = mem_address[2 +: S_WORD];
  assign addr_unused = ^mem_address[1:0];

  logic [N_LINES-1:0] valid;
  logic [N_LINES-1:0] dirty;
  logic [S_TAG-1:0]   tags  [N_LINES];
  logic [S_LINE-1:0]  lines [N_LINES];

  logic              request;
  logic              hit;
  logic [S_LINE-1:0] cur_line;
  logic [31:0]       cur_word;
  logic [31:0]       merged_word;
  logic [S_LINE-1:0] merged_line;

  assign request  = mem_read | mem_write;
  assign hit      = valid[req_index] && (tags[req_index] == req_tag);
  assign cur_line = lines[req_index];
  assign cur_word = cur_line[32*int'(req_word) +: 32];

  // A store hit merges only the enabled lanes; the merged word is also what
  // the store returns on mem_rdata.
  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (mem_byte_enable[i]) merged_word[8*i +: 8] = mem_wdata[8*i +: 8];
    end
    merged_line = cur_line;
    merged_line[32*int'(req_word) +: 32] = merged_word;
  end

  logic idle_hit;
  logic store_hit;
  logic wb_done;
  logic fill_done;

  assign idle_hit  = (state == IDLE) && request && hit;
  assign store_hit = idle_hit && mem_write;
  assign wb_done   = (state == WRITEBACK) && pmem_resp;
  assign fill_done = (state == FILL) && pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (request) begin
          if (hit)                                   state_next = RESP;
          else if (valid[req_index] && dirty[req_index]) state_next = WRITEBACK;
          else                                       state_next = FILL;
        end
      end
      RESP: begin
        mem_resp   = 1'b1;
        state_next = IDLE;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[req_index], req_index, {S_OFFSET{1'b0}}};
        pmem_wdata   = cur_line;
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_index, {S_OFFSET{1'b0}}};
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only valid/dirty need reset; tag and data contents are don't-care until a
  // fill marks the line valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (store_hit && (mem_byte_enable != 4'b0000)) dirty[req_index] <= 1'b1;
      if (wb_done)   dirty[req_index] <= 1'b0;
      if (fill_done) begin
        valid[req_index] <= 1'b1;
        dirty[req_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (store_hit) lines[req_index] <= merged_line;
      if (fill_done) begin
        lines[req_index] <= pmem_rdata;
        tags[req_index]  <= req_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           mem_rdata <= '0;
    else if (idle_hit) mem_rdata <= mem_write ? merged_word : cur_word;
  end

  assert property (@(posedge clk) disable iff (rst) !(pmem_read && pmem_write));

endmodule

// File: tb/tb_l1_data_cache.sv
// Bench for l1_data_cache: directed vector table, randomized traffic against a
// flat word-memory model, spurious pmem_resp and reset-during-fill sequences.
module tb_l1_data_cache;

  localparam int KIND_HIT   = 0;
  localparam int KIND_CLEAN = 1;
  localparam int KIND_DIRTY = 2;
  localparam int KIND_ANY   = 3;

  logic         clk;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic         mem_resp;
  logic [31:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  l1_data_cache dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0]  exp_q[$];
  logic [255:0] backing [logic [31:0]];
  logic [31:0]  gold    [logic [31:0]];

  bit hold = 1'b0;
  int spur_req = 0;
  int spur_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h0000_1004: return 32'hDEAD_BEEF;
      32'h0000_2004: return 32'hCAFE_0001;
      32'h0000_3008: return 32'h0BAD_F00D;
      default:       return a ^ 32'hFFFF_0000;
    endcase
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] l;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) l[32*w +: 32] = init_val(la + 32'(4*w));
    return l;
  endfunction

  function automatic logic [31:0] gold_read(input logic [31:0] a);
    logic [31:0]  aw;
    logic [255:0] l;
    aw = a & 32'hFFFF_FFFC;
    if (gold.exists(aw)) return gold[aw];
    l = get_line(aw & 32'hFFFF_FFE0);
    return l[32*int'(aw[4:2]) +: 32];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- physical memory responder ----------------
  initial begin : responder
    bit          busy;
    int          cnt;
    logic [31:0] lat_addr;
    logic        lat_wr;
    logic [255:0] lat_wdata;
    busy = 1'b0;
    cnt = 0;
    lat_addr = '0;
    lat_wr = 1'b0;
    lat_wdata = '0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        busy = 1'b0;
      end else if (!busy) begin
        busy = 1'b1;
        cnt = $urandom_range(1, 4);
        lat_addr = pmem_address;
        lat_wr = pmem_write;
        lat_wdata = pmem_wdata;
      end else begin
        total++;
        if (pmem_address !== lat_addr || pmem_write !== lat_wr || pmem_read !== !lat_wr ||
            (lat_wr && pmem_wdata !== lat_wdata)) begin
          bad++;
          $display("FAIL pmem_stable: got rd=%0b wr=%0b addr=%08h expected wr=%0b addr=%08h",
                   pmem_read, pmem_write, pmem_address, lat_wr, lat_addr);
        end
        if (!hold) begin
          cnt--;
          if (cnt == 0) begin
            if (lat_wr) backing[lat_addr] = lat_wdata;
            else pmem_rdata = get_line(lat_addr);
            pmem_resp = 1'b1;
            busy = 1'b0;
          end
        end
      end
      if (!busy && !pmem_read && !pmem_write && spur_req != spur_done) begin
        pmem_resp = 1'b1;
        pmem_rdata = '1;
        spur_done = spur_req;
      end
    end
  end

  // ---------------- request driver + scoreboard ----------------
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input logic [31:0] exp_rdata, input int kind,
                        input logic [31:0] exp_wb_addr, input logic [31:0] exp_fill_addr,
                        input logic [31:0] exp_wb_word);
    int cyc, wb_cyc, fill_cyc, presp_cyc;
    bit done, saw_wb, saw_fill;
    logic [31:0] wb_a, fill_a, wb_w, e, aw;
    @(negedge clk);
    check("resp_pulse", 32'(mem_resp), 32'h0);
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wd;
    mem_byte_enable = be;
    exp_q.push_back(exp_rdata);
    aw = addr & 32'hFFFF_FFFC;
    if (wr) gold[aw] = merge(gold_read(aw), wd, be);
    cyc = 0; wb_cyc = -1; fill_cyc = -1; presp_cyc = -1;
    done = 1'b0; saw_wb = 1'b0; saw_fill = 1'b0;
    wb_a = '0; fill_a = '0; wb_w = '0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pmem_write && !saw_wb) begin
        saw_wb = 1'b1; wb_cyc = cyc; wb_a = pmem_address;
        wb_w = pmem_wdata[32*int'(addr[4:2]) +: 32];
      end
      if (pmem_read && !saw_fill) begin
        saw_fill = 1'b1; fill_cyc = cyc; fill_a = pmem_address;
      end
      if (pmem_resp) presp_cyc = cyc;
      if (mem_resp) done = 1'b1;
    end
    if (!done) begin
      check("resp_timeout", 32'(done), 32'h1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("rdata", mem_rdata, e);
      case (kind)
        KIND_HIT: begin
          check("hit_latency", 32'(cyc), 32'd1);
          check("hit_no_pmem", 32'({saw_wb, saw_fill}), 32'h0);
        end
        KIND_CLEAN: begin
          check("clean_no_wb", 32'(saw_wb), 32'h0);
          check("fill_addr", fill_a, exp_fill_addr);
          check("fill_to_resp", 32'(cyc - presp_cyc), 32'd2);
        end
        KIND_DIRTY: begin
          check("wb_addr", wb_a, exp_wb_addr);
          check("wb_word", wb_w, exp_wb_word);
          check("fill_addr", fill_a, exp_fill_addr);
          check("wb_before_fill", 32'(saw_wb && saw_fill && wb_cyc < fill_cyc), 32'h1);
          check("fill_to_resp", 32'(cyc - presp_cyc), 32'd2);
        end
        default: ;
      endcase
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          kind;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
    logic [31:0] wb_word;
  } vec_t;

  vec_t vecs [15];

  initial begin : main
    logic [31:0] a, wd, e;
    logic [3:0]  be;
    logic        rd, wr;
    int          op;
    bit          seen;

    vecs[0]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'h0, 32'hDEAD_BEEF, KIND_CLEAN, 32'h0,    32'h1000, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'h0, 32'hDEAD_BEEF, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1004, 32'h1122_3344, 4'h4, 32'hDE22_BEEF, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'h0, 32'hDE22_BEEF, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h2004, 32'h0,         4'h0, 32'hCAFE_0001, KIND_DIRTY, 32'h1000, 32'h2000, 32'hDE22_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 32'h2004, 32'hFFFF_FFFF, 4'h0, 32'hCAFE_0001, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'h3008, 32'h0,         4'h0, 32'h0BAD_F00D, KIND_CLEAN, 32'h0,    32'h3000, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h1004, 32'h0,         4'h0, 32'hDE22_BEEF, KIND_CLEAN, 32'h0,    32'h1000, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h1000, 32'h0102_0304, 4'hF, 32'h0102_0304, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h1000, 32'h0,         4'h0, 32'h0102_0304, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h101C, 32'h0,         4'h0, 32'hFFFF_101C, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[11] = '{1'b1, 1'b1, 32'h2000, 32'hAABB_CCDD, 4'h3, 32'hFFFF_CCDD, KIND_DIRTY, 32'h1000, 32'h2000, 32'h0102_0304};
    vecs[12] = '{1'b1, 1'b0, 32'h2000, 32'h0,         4'h0, 32'hFFFF_CCDD, KIND_HIT,   32'h0,    32'h0,    32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h1024, 32'h0,         4'h0, 32'hFFFF_1024, KIND_CLEAN, 32'h0,    32'h1020, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h2004, 32'h0,         4'h0, 32'hCAFE_0001, KIND_HIT,   32'h0,    32'h0,    32'h0};

    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = '0;
    mem_address = '0;
    mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_resp",   32'(mem_resp),   32'h0);
    check("rst_mem_rdata",  mem_rdata,       32'h0);
    check("rst_pmem_read",  32'(pmem_read),  32'h0);
    check("rst_pmem_write", 32'(pmem_write), 32'h0);
    check("rst_pmem_addr",  pmem_address,    32'h0);
    check("rst_pmem_wdata", 32'(pmem_wdata != '0), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].kind, vecs[i].wb_addr, vecs[i].fill_addr,
             vecs[i].wb_word);
    end

    for (int n = 0; n < 160; n++) begin
      a = (32'($urandom_range(1, 4)) << 12) | (32'($urandom_range(0, 1)) << 5) |
          (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      op = $urandom_range(0, 3);
      rd = (op == 0 || op == 3);
      wr = (op != 0);
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      e = wr ? merge(gold_read(a), wd, be) : gold_read(a);
      do_req(rd, wr, a, wd, be, e, KIND_ANY, 32'h0, 32'h0, 32'h0);
    end

    // pmem_resp while idle must not disturb the resident line
    do_req(1'b1, 1'b0, 32'h1044, 32'h0, 4'h0, gold_read(32'h1044), KIND_ANY, 32'h0, 32'h0, 32'h0);
    spur_req++;
    repeat (4) begin
      @(negedge clk);
      check("spur_no_resp", 32'({mem_resp, pmem_read, pmem_write}), 32'h0);
    end
    do_req(1'b1, 1'b0, 32'h1044, 32'h0, 4'h0, 32'hFFFF_1044, KIND_HIT, 32'h0, 32'h0, 32'h0);

    // reset while a fill is outstanding
    @(negedge clk);
    hold = 1'b1;
    mem_read = 1'b1;
    mem_address = 32'h5044;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (pmem_read) seen = 1'b1;
    end
    check("rst_fill_started", 32'(seen), 32'h1);
    check("rst_fill_addr", pmem_address, 32'h5040);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pmem_read", 32'(pmem_read), 32'h0);
    check("rst_mid_pmem_write", 32'(pmem_write), 32'h0);
    check("rst_mid_mem_resp", 32'(mem_resp), 32'h0);
    rst = 1'b0;
    mem_read = 1'b0;
    hold = 1'b0;
    gold.delete();
    do_req(1'b1, 1'b0, 32'h5044, 32'h0, 4'h0, 32'hFFFF_5044, KIND_CLEAN, 32'h0, 32'h5040, 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
